gate_stim_gen: RTL and testbench
================================

Name: gate_stim_gen

Overview:
Synthesizable two-channel stimulus generator that sits directly upstream of the switch-level gate cells (nand_gate and siblings) and drives their vin1/vin2 inputs. Each channel toggles its output at a programmable half-period for a programmable number of toggles, and both channels run in parallel from a single start command. Completion is signalled with a done pulse so that a downstream checker or bench can sample vout.

Parameters:
CNT_W, 16, width of half-period fields and per-channel cycle counters
TOG_W, 8, width of toggle-count fields and remaining-toggle counters

Ports:
clk  input  1  single system clock, rising-edge
rst_n  input  1  synchronous active-low reset
start  input  1  run request; sampled only in IDLE
half_per1  input  CNT_W  channel-1 half-period in clk cycles; 0 treated as 1
half_per2  input  CNT_W  channel-2 half-period in clk cycles; 0 treated as 1
tog_cnt1  input  TOG_W  number of vin1 toggles per run
tog_cnt2  input  TOG_W  number of vin2 toggles per run
vin1  output  1  channel-1 stimulus to gate input A
vin2  output  1  channel-2 stimulus to gate input B
busy  output  1  high while in RUN
done  output  1  one-cycle pulse in DONE

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE; vin1=vin2=0; busy=0; done=0; all counters cleared. This applies equally when reset is asserted mid-run, and it aborts the run without a done pulse.
- FSM states:
  - IDLE: waits for start.
  - RUN: both channels active.
  - DONE: single cycle, then returns to IDLE.
- IDLE -> RUN: start=1 at edge k.
  - Latch half_per1/2 (with 0 mapped to 1) and tog_cnt1/2.
  - Set rem1/rem2 to the toggle counts and clear cnt1/cnt2.
  - Force vin1=vin2=0.
- Per channel in RUN, at each edge:
  - If rem>0 and cnt==H-1: invert vin, set cnt=0, decrement rem.
  - Else if rem>0: increment cnt.
  - If rem==0: hold vin and cnt.
- Resulting timing: the first toggle occurs at edge k+H, and the n-th toggle at edge k+n*H. Channels are fully independent, so toggles on both channels in the same edge are legal.
- RUN -> DONE: at the first edge where the registered rem1==0 and rem2==0. Let T=max(H1*N1, H2*N2). DONE is entered at edge k+T+1, and done=1 for exactly that one cycle. DONE -> IDLE on the next edge.
- Degenerate case N1=N2=0: RUN lasts one cycle, and done is asserted at edge k+1.
- busy=1 exactly while state==RUN.
- start is ignored in RUN and DONE. Input changes during RUN are ignored because the configuration is latched.
- After a run, vin1/vin2 hold their final values in IDLE (0 if the toggle count was even, 1 if odd) until reset or the next start.
- Counter arithmetic:
  - cnt is unsigned CNT_W and never exceeds H-1, so it cannot wrap.
  - rem is unsigned TOG_W and never decrements below 0.
  - The maximum half-period is 2^CNT_W-1.
- Outputs are registered, with no combinational path from the inputs to vin1, vin2, busy or done.

Decomposition:
- Shared package gate_stim_pkg holds:
  - state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - default CNT_W/TOG_W constants;
  - a helper for mapping half-period 0 to 1.
- One natural sub-module, stim_toggle_ch:
  - Holds the per-channel cnt/rem/vin registers.
  - Ports: clk, rst_n, load, run, half_per, tog_cnt, vout, idle (idle=1 when rem==0).
  - Instantiated twice.
- The top level contains the FSM and the busy/done logic only.

Test Plan:
1. Reset then start with H1=50, N1=10, H2=100, N2=10. Required response:
   - vin1 toggles at k+50, 100, …, 500.
   - vin2 toggles at k+100, …, 1000.
   - busy is high from k+1 to k+1001.
   - done is high only in the cycle after edge k+1001.
   - vin1=vin2=0 at the end.
2. H1=H2=0 (treated as 1), N1=3, N2=1. Required response:
   - vin1 toggles at k+1, 2, 3 and ends at 1.
   - vin2 toggles at k+1 and ends at 1.
   - done at edge k+4.
3. N1=N2=0 with any H. Required response: vin1 and vin2 stay 0, busy is high for 1 cycle, and done is at edge k+1.
4. Reassert start and change half_per1/tog_cnt1 mid-run (H1=4, N1=4, then input changed to H1=1). Required response: no restart, the toggle timing still follows H1=4, and exactly one done pulse at edge k+17.
5. Drop rst_n at k+30 during the scenario-1 run. Required response:
   - At the next edge, vin1=vin2=0, busy=0, and no done pulse.
   - A fresh start after rst_n returns high runs the full scenario-1 timing again.
6. Odd toggle counts (N1=5, N2=3, H1=H2=2), followed by a second start. Required response:
   - vin1=vin2=1 is held in IDLE after the first run.
   - Both are forced to 0 at the second start edge.

Source files
------------

// File: rtl/gate_stim_pkg.sv
// rtl/gate_stim_pkg.sv - shared types, defaults and helpers for the gate stimulus generator
//
// Contents:
//   state_e       FSM state encoding (IDLE=0, RUN=1, DONE=2)
//   DEF_CNT_W     default width of half-period fields and cycle counters
//   DEF_TOG_W     default width of toggle-count fields and remaining-toggle counters
//   map_half_per  maps a half-period of 0 to 1 so every channel makes progress
package gate_stim_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int DEF_CNT_W = 16;
  localparam int DEF_TOG_W = 8;

  // Operates on a 32-bit container; callers cast to and from their field width.
  function automatic logic [31:0] map_half_per(input logic [31:0] hp);
    return (hp == 32'd0) ? 32'd1 : hp;
  endfunction

endpackage

// File: rtl/gate_stim_gen_if.sv
// rtl/gate_stim_gen_if.sv - control/stimulus bundle between a run controller and gate_stim_gen
//
// Signals:
//   start               run request (sampled only while the generator is idle)
//   half_per1/half_per2 per-channel half-period in clk cycles (0 behaves as 1)
//   tog_cnt1/tog_cnt2   per-channel number of toggles per run
//   vin1/vin2           registered stimulus outputs to gate inputs A/B
//   busy                high while a run is in progress
//   done                one-cycle completion pulse
// Modports:
//   master  drives start and configuration, observes stimulus and status
//   slave   the generator side
interface gate_stim_gen_if
  import gate_stim_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int TOG_W = DEF_TOG_W
) ();

  logic             start;
  logic [CNT_W-1:0] half_per1;
  logic [CNT_W-1:0] half_per2;
  logic [TOG_W-1:0] tog_cnt1;
  logic [TOG_W-1:0] tog_cnt2;
  logic             vin1;
  logic             vin2;
  logic             busy;
  logic             done;

  modport master (
    output start, half_per1, half_per2, tog_cnt1, tog_cnt2,
    input  vin1, vin2, busy, done
  );

  modport slave (
    input  start, half_per1, half_per2, tog_cnt1, tog_cnt2,
    output vin1, vin2, busy, done
  );

endinterface

// File: rtl/stim_toggle_ch.sv
// rtl/stim_toggle_ch.sv - one stimulus channel: toggles vout every half_per cycles, tog_cnt times
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     synchronous active-low reset
//   load      latch half_per/tog_cnt, clear the cycle counter, force vout low
//   run       advance the channel this cycle
//   half_per  half-period in clk cycles (0 behaves as 1)
//   tog_cnt   number of toggles to produce
//   vout      registered stimulus output
//   idle      high when no toggles remain
module stim_toggle_ch
  import gate_stim_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int TOG_W = DEF_TOG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             run,
  input  logic [CNT_W-1:0] half_per,
  input  logic [TOG_W-1:0] tog_cnt,
  output logic             vout,
  output logic             idle
);

  logic [CNT_W-1:0] h_q,   h_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TOG_W-1:0] rem_q, rem_d;
  logic             vin_q, vin_d;

  always_comb begin
    h_d   = h_q;
    cnt_d = cnt_q;
    rem_d = rem_q;
    vin_d = vin_q;
    if (load) begin
      h_d   = CNT_W'(map_half_per(32'(half_per)));
      cnt_d = '0;
      rem_d = tog_cnt;
      vin_d = 1'b0;
    end else if (run && (rem_q != '0)) begin
      // h_q is never 0, so h_q-1 cannot underflow and cnt stays below h_q.
      if (cnt_q == h_q - CNT_W'(1)) begin
        vin_d = ~vin_q;
        cnt_d = '0;
        rem_d = rem_q - TOG_W'(1);
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_q   <= CNT_W'(1);
      cnt_q <= '0;
      rem_q <= '0;
      vin_q <= 1'b0;
    end else begin
      h_q   <= h_d;
      cnt_q <= cnt_d;
      rem_q <= rem_d;
      vin_q <= vin_d;
    end
  end

  assign vout = vin_q;
  assign idle = (rem_q == '0);

endmodule

// File: rtl/gate_stim_gen.sv
// rtl/gate_stim_gen.sv - two-channel toggle stimulus generator for switch-level gate cells
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  synchronous active-low reset; aborts a run without a done pulse
//   bus    gate_stim_gen_if slave: start/config in, vin1/vin2/busy/done out
// The top holds the IDLE/RUN/DONE sequencer; each channel's counters live in stim_toggle_ch.
module gate_stim_gen
  import gate_stim_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int TOG_W = DEF_TOG_W
) (
  input  logic              clk,
  input  logic              rst_n,
  gate_stim_gen_if.slave    bus
);

  state_e state_q, state_d;
  logic   busy_q,  busy_d;
  logic   done_q,  done_d;

  logic load;
  logic run;
  logic idle1;
  logic idle2;
  logic vout1;
  logic vout2;

  // Configuration is captured only on the IDLE->RUN edge, which is what makes
  // start and config changes during RUN/DONE harmless.
  assign load = (state_q == ST_IDLE) && bus.start;
  assign run  = (state_q == ST_RUN);

  stim_toggle_ch #(.CNT_W(CNT_W), .TOG_W(TOG_W)) u_ch1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .run      (run),
    .half_per (bus.half_per1),
    .tog_cnt  (bus.tog_cnt1),
    .vout     (vout1),
    .idle     (idle1)
  );

  stim_toggle_ch #(.CNT_W(CNT_W), .TOG_W(TOG_W)) u_ch2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .run      (run),
    .half_per (bus.half_per2),
    .tog_cnt  (bus.tog_cnt2),
    .vout     (vout2),
    .idle     (idle2)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.start) state_d = ST_RUN;
      // Both channels report idle from their registered remaining counts, so
      // DONE follows the final toggle by one edge.
      ST_RUN:  if (idle1 && idle2) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.vin1 = vout1;
  assign bus.vin2 = vout2;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_gate_stim_gen.sv
// tb/tb_gate_stim_gen.sv - self-checking bench for gate_stim_gen
module tb_gate_stim_gen;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  // Expected {vin1, vin2, busy, done} per sampled cycle.
  logic [3:0] exp_q[$];

  gate_stim_gen_if #(.CNT_W(16), .TOG_W(8)) bus ();

  gate_stim_gen #(.CNT_W(16), .TOG_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  // Expected outputs after edge k+t of a run started at edge k, derived from the
  // toggle timing: toggle n of a channel lands on edge k+n*H.
  function automatic logic [3:0] expect_at(input int t, input int h1, input int n1,
                                           input int h2, input int n2);
    int tt;
    int c1;
    int c2;
    tt = (h1 * n1 > h2 * n2) ? h1 * n1 : h2 * n2;
    c1 = t / h1;
    if (c1 > n1) c1 = n1;
    c2 = t / h2;
    if (c2 > n2) c2 = n2;
    return {c1[0], c2[0], (t <= tt), (t == tt + 1)};
  endfunction

  // Starts a run at the next edge and checks every cycle through the return to
  // IDLE. rst_at >= 0 pulls rst_n low so that the reset edge is k+rst_at.
  // mutate holds start high and rewrites channel-1 config after the start edge.
  task automatic run_check(input string name, input int h1, input int n1,
                           input int h2, input int n2, input int rst_at, input bit mutate);
    int eh1;
    int eh2;
    int tt;
    int total;
    logic [3:0] got;
    logic [3:0] exp_v;
    eh1 = (h1 == 0) ? 1 : h1;
    eh2 = (h2 == 0) ? 1 : h2;
    tt = (eh1 * n1 > eh2 * n2) ? eh1 * n1 : eh2 * n2;
    total = (rst_at >= 0) ? rst_at : tt + 2;
    @(negedge clk);
    bus.start     = 1'b1;
    bus.half_per1 = 16'(h1);
    bus.half_per2 = 16'(h2);
    bus.tog_cnt1  = 8'(n1);
    bus.tog_cnt2  = 8'(n2);
    for (int t = 0; t <= total; t++) begin
      if (rst_at >= 0 && t >= rst_at) exp_q.push_back(4'b0000);
      else exp_q.push_back(expect_at(t, eh1, n1, eh2, n2));
    end
    for (int t = 0; t <= total; t++) begin
      @(negedge clk);
      got = {bus.vin1, bus.vin2, bus.busy, bus.done};
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL %s t=%0d scoreboard empty, got %b", name, t, got);
      end else begin
        exp_v = exp_q.pop_front();
        if (got !== exp_v)
          $display("FAIL %s t=%0d {vin1,vin2,busy,done} got %b want %b", name, t, got, exp_v);
        else
          n_pass++;
      end
      if (mutate && t < total) begin
        bus.start     = 1'b1;
        bus.half_per1 = 16'd1;
        bus.tog_cnt1  = 8'd9;
      end else begin
        bus.start = 1'b0;
      end
      if (rst_at >= 0 && t == rst_at - 1) rst_n = 1'b0;
      else rst_n = 1'b1;
    end
    bus.start = 1'b0;
    rst_n     = 1'b1;
  endtask

  task automatic test_reset();
    logic [3:0] got;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.half_per1 = '0;
    bus.half_per2 = '0;
    bus.tog_cnt1 = '0;
    bus.tog_cnt2 = '0;
    repeat (3) @(negedge clk);
    got = {bus.vin1, bus.vin2, bus.busy, bus.done};
    n_checks++;
    if (got !== 4'b0000) $display("FAIL reset_state got %b want 0000", got);
    else n_pass++;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    got = {bus.vin1, bus.vin2, bus.busy, bus.done};
    n_checks++;
    if (got !== 4'b0000) $display("FAIL idle_after_reset got %b want 0000", got);
    else n_pass++;
  endtask

  task automatic test_long_run();
    run_check("long_run", 50, 10, 100, 10, -1, 1'b0);
  endtask

  task automatic test_zero_half_period();
    run_check("zero_half_period", 0, 3, 0, 1, -1, 1'b0);
  endtask

  task automatic test_zero_toggles();
    run_check("zero_toggles", 7, 0, 3, 0, -1, 1'b0);
  endtask

  task automatic test_mid_run_changes();
    run_check("mid_run_changes", 4, 4, 3, 2, -1, 1'b1);
  endtask

  task automatic test_reset_abort();
    run_check("reset_abort", 50, 10, 100, 10, 30, 1'b0);
    run_check("rerun_after_reset", 50, 10, 100, 10, -1, 1'b0);
  endtask

  task automatic test_odd_hold();
    logic [3:0] got;
    run_check("odd_first_run", 2, 5, 2, 3, -1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      got = {bus.vin1, bus.vin2, bus.busy, bus.done};
      n_checks++;
      if (got !== 4'b1100) $display("FAIL odd_idle_hold cycle=%0d got %b want 1100", i, got);
      else n_pass++;
    end
    run_check("odd_second_start", 3, 2, 1, 1, -1, 1'b0);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    bus.start = 1'b0;
    bus.half_per1 = '0;
    bus.half_per2 = '0;
    bus.tog_cnt1 = '0;
    bus.tog_cnt2 = '0;
    test_reset();
    test_long_run();
    test_zero_half_period();
    test_zero_toggles();
    test_mid_run_changes();
    test_reset_abort();
    test_odd_hold();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
